dispatch_stage: RTL and testbench

- Producer side of the dispatch-to-scheduler link: accepts renamed instructions from decode, buffers them, builds each instruction's RS dependency mask, and issues them into the reservation station.
- Tracks, per architectural register, which in-flight RS entry will produce it.
- Entries are released when the scheduler's OR'd ready mask reports them complete.
- Sits between decode and scheduler in each execution pipe.

---
 rtl/dispatch_stage.sv | 141 ++++++++++++++
 tb/tb_dispatch_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_stage.sv
// dispatch_stage: skid-buffers renamed instructions, builds RS dependency
// masks from a per-register producer table and issues into the scheduler.
module dispatch_stage #(
  parameter int RS_ENTRIES    = 8,
  parameter int NUM_ARCH_REGS = 32,
  parameter int BUF_DEPTH     = 2,
  parameter int PKT_W         = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [$clog2(NUM_ARCH_REGS)-1:0] in_rs1,
  input  logic [$clog2(NUM_ARCH_REGS)-1:0] in_rs2,
  input  logic [$clog2(NUM_ARCH_REGS)-1:0] in_rd,
  input  logic                             in_uses_rs1,
  input  logic                             in_uses_rs2,
  input  logic                             in_writes_rd,
  input  logic [PKT_W-1:0]                 in_pkt,
  input  logic [RS_ENTRIES-1:0]            clear_mask,
  input  logic                             rs_full,
  input  logic [$clog2(RS_ENTRIES)-1:0]    rs_entry_idx,
  output logic                             disp_valid,
  output logic [RS_ENTRIES-1:0]            dependency_mask,
  output logic [PKT_W-1:0]                 disp_pkt
);

  localparam int EW = $clog2(RS_ENTRIES);
  localparam int RW = $clog2(NUM_ARCH_REGS);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [RW-1:0]    rs1;
    logic [RW-1:0]    rs2;
    logic [RW-1:0]    rd;
    logic             u1;
    logic             u2;
    logic             wr;
    logic [PKT_W-1:0] pkt;
  } ent_t;

  ent_t              buf_q [BUF_DEPTH];
  logic [PW-1:0]     wp_q, wp_d;
  logic [PW-1:0]     rp_q, rp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NUM_ARCH_REGS-1:0] tv_q, tv_d;
  logic [EW-1:0]     te_q [NUM_ARCH_REGS];
  logic [EW-1:0]     te_d [NUM_ARCH_REGS];

  ent_t in_ent;
  ent_t head;
  logic empty;
  logic full;
  logic push;
  logic pop;

  assign in_ent = {in_rs1, in_rs2, in_rd, in_uses_rs1,
                   in_uses_rs2, in_writes_rd, in_pkt};
  assign head  = buf_q[rp_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(BUF_DEPTH));

  assign in_ready   = !full && !flush;
  assign disp_valid = !empty && !rs_full && !flush;
  assign disp_pkt   = empty ? '0 : head.pkt;
  assign push       = in_valid && in_ready;
  assign pop        = disp_valid;

  // Dependency mask from the head; same-cycle completions are bypassed
  always_comb begin
    dependency_mask = '0;
    if (disp_valid) begin
      if (head.u1 && head.rs1 != '0 && tv_q[head.rs1]
          && !clear_mask[te_q[head.rs1]])
        dependency_mask[te_q[head.rs1]] = 1'b1;
      if (head.u2 && head.rs2 != '0 && tv_q[head.rs2]
          && !clear_mask[te_q[head.rs2]])
        dependency_mask[te_q[head.rs2]] = 1'b1;
    end
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = wp_q + PW'(1);
      if (pop)  rp_d = rp_q + PW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (!push && pop) cnt_d = cnt_q - CW'(1);
    end
  end

  // Producer table: drop completed producers, then record the issuing rd
  always_comb begin
    for (int r = 0; r < NUM_ARCH_REGS; r++) begin
      tv_d[r] = tv_q[r] && !clear_mask[te_q[r]];
      te_d[r] = te_q[r];
      if (disp_valid && head.wr && r != 0
          && head.rd == RW'(r)) begin
        tv_d[r] = 1'b1;
        te_d[r] = rs_entry_idx;
      end
    end
    if (flush) tv_d = '0;
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) buf_q[wp_q] <= in_ent;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Producer table state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tv_q <= '0;
      for (int r = 0; r < NUM_ARCH_REGS; r++) te_q[r] <= '0;
    end else begin
      tv_q <= tv_d;
      for (int r = 0; r < NUM_ARCH_REGS; r++) te_q[r] <= te_d[r];
    end
  end

endmodule

// File: tb/tb_dispatch_stage.sv
// tb_dispatch_stage: directed vector table, async reset sequence and
// randomized traffic against a queue/array reference model.
module tb_dispatch_stage;

  logic        clk = 0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_uses_rs1, in_uses_rs2, in_writes_rd;
  logic [63:0] in_pkt;
  logic [7:0]  clear_mask;
  logic        rs_full;
  logic [2:0]  rs_entry_idx;
  logic        disp_valid;
  logic [7:0]  dependency_mask;
  logic [63:0] disp_pkt;

  int passed = 0;
  int total  = 0;

  dispatch_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
    .in_writes_rd(in_writes_rd), .in_pkt(in_pkt),
    .clear_mask(clear_mask), .rs_full(rs_full),
    .rs_entry_idx(rs_entry_idx), .disp_valid(disp_valid),
    .dependency_mask(dependency_mask), .disp_pkt(disp_pkt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl, iv;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, wr;
    logic [63:0] pkt;
    logic [7:0]  clr;
    logic        full;
    logic [2:0]  idx;
    logic        e_rdy, e_dv;
    logic [7:0]  e_mask;
    logic [63:0] e_pkt;
  } vec_t;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    bit          u1, u2, wr;
    logic [63:0] pkt;
  } ins_t;

  vec_t vt[$];
  ins_t mq[$];
  bit   pv[32];
  int   pe[32];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic vec_t mk(
    logic fl, logic iv, logic [4:0] rs1, logic [4:0] rs2,
    logic [4:0] rd, logic u1, logic u2, logic wr,
    logic [63:0] pkt, logic [7:0] clr, logic full, logic [2:0] idx,
    logic er, logic edv, logic [7:0] em, logic [63:0] ep);
    vec_t v;
    v.fl = fl; v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.u1 = u1; v.u2 = u2; v.wr = wr; v.pkt = pkt; v.clr = clr;
    v.full = full; v.idx = idx; v.e_rdy = er; v.e_dv = edv;
    v.e_mask = em; v.e_pkt = ep;
    return v;
  endfunction

  task automatic idle_inputs();
    flush = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_uses_rs1 = 0; in_uses_rs2 = 0; in_writes_rd = 0;
    in_pkt = 0; clear_mask = 0; rs_full = 0; rs_entry_idx = 0;
  endtask

  task automatic apply(input vec_t v);
    flush = v.fl; in_valid = v.iv; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_rd = v.rd; in_uses_rs1 = v.u1; in_uses_rs2 = v.u2;
    in_writes_rd = v.wr; in_pkt = v.pkt; clear_mask = v.clr;
    rs_full = v.full; rs_entry_idx = v.idx;
  endtask

  // One source's contribution: live producer not completing this cycle
  function automatic logic [7:0] dep(logic [4:0] s, bit u,
                                     logic [7:0] clr);
    if (u && s != 0 && pv[s] && !clr[pe[s]])
      return 8'(1) << pe[s];
    return 8'h00;
  endfunction

  task automatic build_table();
    // add x5 <- x1,x2 ; issues into entry 3 with no deps
    vt.push_back(mk(0,1, 1,2,5, 1,1,1, 64'h100, 0,0,0, 1,0,8'h00,0));
    vt.push_back(mk(0,0, 0,0,0, 0,0,0, 0, 0,0,3, 1,1,8'h00,64'h100));
    // reader of x5 twice -> single bit 3
    vt.push_back(mk(0,1, 5,5,6, 1,1,1, 64'h101, 0,0,0, 1,0,8'h00,0));
    vt.push_back(mk(0,0, 0,0,0, 0,0,0, 0, 0,0,4, 1,1,8'h08,64'h101));
    vt.push_back(mk(0,0, 0,0,0, 0,0,0, 0, 8'h08,0,0, 1,0,8'h00,0));
    vt.push_back(mk(0,1, 5,0,0, 1,0,0, 64'h102, 0,0,0, 1,0,8'h00,0));
    vt.push_back(mk(0,0, 0,0,0, 0,0,0, 0, 0,0,5, 1,1,8'h00,64'h102));
    // rs_full stall with three push attempts
    vt.push_back(mk(0,1, 6,0,7, 1,0,1, 64'h103, 0,1,0, 1,0,8'h00,0));
    vt.push_back(mk(0,1, 7,0,8, 1,0,1, 64'h104, 0,1,0, 1,0,8'h00,64'h103));
    vt.push_back(mk(0,1, 1,1,1, 0,0,0, 64'h105, 0,1,0, 0,0,8'h00,64'h103));
    vt.push_back(mk(0,0, 0,0,0, 0,0,0, 0, 0,1,0, 0,0,8'h00,64'h103));
    vt.push_back(mk(0,0, 0,0,0, 0,0,0, 0, 0,1,0, 0,0,8'h00,64'h103));
    vt.push_back(mk(0,0, 0,0,0, 0,0,0, 0, 0,0,2, 0,1,8'h10,64'h103));
    // x7 producer (entry 2) completes in the same cycle -> bypass
    vt.push_back(mk(0,0, 0,0,0, 0,0,0, 0, 8'h04,0,6, 1,1,8'h00,64'h104));
    // x0 handling
    vt.push_back(mk(0,1, 0,8,0, 1,1,1, 64'h106, 0,0,0, 1,0,8'h00,0));
    vt.push_back(mk(0,0, 0,0,0, 0,0,0, 0, 0,0,1, 1,1,8'h40,64'h106));
    vt.push_back(mk(0,1, 0,0,0, 1,1,0, 64'h107, 0,0,0, 1,0,8'h00,0));
    vt.push_back(mk(0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1,1,8'h00,64'h107));
    // flush with two buffered, table x6/x8/x9 valid
    vt.push_back(mk(0,1, 0,0,9, 0,0,1, 64'h108, 0,0,0, 1,0,8'h00,0));
    vt.push_back(mk(0,0, 0,0,0, 0,0,0, 0, 0,0,7, 1,1,8'h00,64'h108));
    vt.push_back(mk(0,1, 6,9,10, 1,1,1, 64'h109, 0,1,0, 1,0,8'h00,0));
    vt.push_back(mk(0,1, 8,0,0, 1,0,0, 64'h10A, 0,1,0, 1,0,8'h00,64'h109));
    vt.push_back(mk(1,1, 1,1,1, 0,0,0, 64'h10B, 0,1,0, 0,0,8'h00,64'h109));
    vt.push_back(mk(0,1, 6,9,0, 1,1,0, 64'h10C, 0,0,0, 1,0,8'h00,0));
    vt.push_back(mk(0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1,1,8'h00,64'h10C));
    vt.push_back(mk(1,1, 0,0,0, 0,0,0, 64'h10D, 0,0,0, 0,0,8'h00,0));
    vt.push_back(mk(0,0, 0,0,0, 0,0,0, 0, 0,0,0, 1,0,8'h00,0));
  endtask

  initial begin
    logic        e_rdy, e_dv;
    logic [7:0]  e_mask;
    logic [63:0] e_pkt;
    ins_t        ni;

    idle_inputs();
    rst = 0;
    #2;
    chk("rst_ready", 64'(in_ready), 64'h1);
    chk("rst_dv", 64'(disp_valid), 64'h0);
    chk("rst_mask", 64'(dependency_mask), 64'h0);
    chk("rst_pkt", disp_pkt, 64'h0);
    @(negedge clk);
    rst = 1;

    build_table();
    foreach (vt[i]) begin
      @(posedge clk); #1;
      apply(vt[i]);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 64'(in_ready), 64'(vt[i].e_rdy));
      chk($sformatf("v%0d_dv", i), 64'(disp_valid), 64'(vt[i].e_dv));
      chk($sformatf("v%0d_mask", i), 64'(dependency_mask),
          64'(vt[i].e_mask));
      chk($sformatf("v%0d_pkt", i), disp_pkt, vt[i].e_pkt);
    end

    // Async reset while two instructions are buffered
    @(posedge clk); #1;
    idle_inputs();
    rs_full = 1; in_valid = 1; in_pkt = 64'h200;
    @(posedge clk); #1;
    in_pkt = 64'h201;
    @(posedge clk); #1;
    in_valid = 0; rs_full = 0;
    #2;
    chk("pre_rst_dv", 64'(disp_valid), 64'h1);
    chk("pre_rst_pkt", disp_pkt, 64'h200);
    rst = 0;
    #1;
    chk("async_rst_dv", 64'(disp_valid), 64'h0);
    chk("async_rst_pkt", disp_pkt, 64'h0);
    chk("async_rst_ready", 64'(in_ready), 64'h1);
    chk("async_rst_mask", 64'(dependency_mask), 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    chk("post_rst_dv", 64'(disp_valid), 64'h0);

    // Randomized traffic against the reference model
    mq.delete();
    for (int r = 0; r < 32; r++) begin pv[r] = 0; pe[r] = 0; end
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      flush        = ($urandom_range(0, 19) == 0);
      in_valid     = ($urandom_range(0, 3) != 0);
      in_rs1       = 5'($urandom_range(0, 7));
      in_rs2       = 5'($urandom_range(0, 7));
      in_rd        = 5'($urandom_range(0, 7));
      in_uses_rs1  = 1'($urandom_range(0, 1));
      in_uses_rs2  = 1'($urandom_range(0, 1));
      in_writes_rd = ($urandom_range(0, 3) != 0);
      in_pkt       = {$urandom, $urandom};
      clear_mask   = 8'(1) << $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 0) clear_mask = 0;
      rs_full      = ($urandom_range(0, 3) == 0);
      rs_entry_idx = 3'($urandom_range(0, 7));
      @(negedge clk);

      e_rdy  = (mq.size() < 2) && !flush;
      e_dv   = (mq.size() > 0) && !rs_full && !flush;
      e_pkt  = (mq.size() > 0) ? mq[0].pkt : 64'h0;
      e_mask = 0;
      if (e_dv)
        e_mask = dep(mq[0].rs1, mq[0].u1, clear_mask)
               | dep(mq[0].rs2, mq[0].u2, clear_mask);
      chk("rnd_ready", 64'(in_ready), 64'(e_rdy));
      chk("rnd_dv", 64'(disp_valid), 64'(e_dv));
      chk("rnd_mask", 64'(dependency_mask), 64'(e_mask));
      chk("rnd_pkt", disp_pkt, e_pkt);

      for (int r = 0; r < 32; r++)
        if (pv[r] && clear_mask[pe[r]]) pv[r] = 0;
      if (flush) begin
        mq.delete();
        for (int r = 0; r < 32; r++) pv[r] = 0;
      end else begin
        if (e_dv) begin
          if (mq[0].wr && mq[0].rd != 0) begin
            pv[mq[0].rd] = 1;
            pe[mq[0].rd] = int'(rs_entry_idx);
          end
          void'(mq.pop_front());
        end
        if (in_valid && e_rdy) begin
          ni.rs1 = in_rs1; ni.rs2 = in_rs2; ni.rd = in_rd;
          ni.u1 = in_uses_rs1; ni.u2 = in_uses_rs2;
          ni.wr = in_writes_rd; ni.pkt = in_pkt;
          mq.push_back(ni);
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
